data_memory_unit: RTL and testbench
===================================

// Module: data_memory_unit
//
// PURPOSE
//  Memory-stage data memory responder. Consumes the memory-stage register outputs:
//  aluResult as the address, data as the store value, plus the read/write enables.
//  Performs word loads/stores with a fixed multi-cycle access latency.
//  Drives `ready` low so hazard/freeze logic stalls the pipeline until the access completes.
//  Returns load data to the write-back stage.
//
// PARAMETERS
//  DEPTH      64       number of 32-bit words in the array (power of 2)
//  BASE_ADDR  1024     byte address mapped to word 0
//  LATENCY    4        ACCESS-state cycles per transfer (>=1)
//
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   synchronous reset, active-low
//  memoryReadEnabled   in   1   load request; held stable by requester until ready
//  memoryWriteEnabled  in   1   store request; held stable by requester until ready
//  address             in   32  byte address (aluResult)
//  writeData           in   32  store data (Rm value)
//  readData            out  32  load result, registered
//  ready               out  1   0 = stall pipeline; 1 = no access pending or access done
//  error               out  1   access fault pulse (only with MEM_ALIGN_CHECK_EN)
//
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge):
//    - state=IDLE, counter=0, readData=0, error=0.
//    - Array contents are not cleared.
//  - Word index = (address - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits (wraps).
//  - FSM has three states: IDLE, ACCESS and DONE.
//  - IDLE:
//    - With no request: ready=1.
//    - With either enable high at edge T:
//      - Latch index, writeData and the op. Write wins if both enables are high.
//      - Load counter=LATENCY-1 and go to ACCESS.
//      - ready is combinational and is 0 in the request cycle T.
//  - ACCESS:
//    - ready=0.
//    - Counter decrements each cycle.
//    - At the edge where counter==0:
//      - A store writes the array.
//      - A load registers array[index] into readData.
//      - Go to DONE.
//  - DONE:
//    - ready=1 for exactly one cycle, then go to IDLE.
//    - The still-held request is NOT re-accepted in DONE.
//  - Timing: request first seen in cycle T gives ready=1 in cycle T+LATENCY+1.
//    - Default total is 5 cycles.
//  - Latched operands are used throughout. Enables dropping mid-ACCESS do not abort the access.
//  - readData holds its last load value through stores and idle cycles.
//  - Reset mid-ACCESS: the pending store is discarded (array unchanged) and readData clears to 0.
//  - Back-to-back requests:
//    - The new request is sampled in IDLE, one cycle after DONE.
//    - Minimum spacing is LATENCY+2 cycles.
//
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    - Fault when address[1:0]!=0, or address<BASE_ADDR, or address>=BASE_ADDR+4*DEPTH.
//    - On a fault:
//      - error=1 during DONE.
//      - Store is suppressed.
//      - readData <= 0 for a faulting load.
//    - Timing is unchanged.
//  - MEM_ALIGN_CHECK_EN undefined:
//    - address[1:0] ignored, out-of-range addresses wrap, error tied to 0.
//
// TESTING
//  - Reset: rst=0 for 2 cycles -> readData=0, ready=1, error=0.
//  - Store/load, LATENCY=4:
//    - Write 0xDEADBEEF at 1032 -> ready low for cycles T..T+4, high at T+5.
//    - Then read 1032 -> readData=0xDEADBEEF at T'+5.
//  - Both enables high with writeData=0x11 at 1024 -> treated as a store.
//    - A subsequent read of 1024 returns 0x11.
//  - Enables dropped at T+2 of a store of 0x55 to 1028 -> store still completes, ready at T+5.
//    - A read of 1028 returns 0x55.
//  - rst=0 at T+2 of a store of 0x77 to 1036 (old value 0x0) -> FSM in IDLE after reset.
//    - A read of 1036 returns 0x0.
//  - MEM_ALIGN_CHECK_EN: read at 1026, and read at BASE_ADDR+4*DEPTH -> each gives error=1 in DONE, readData=0.
//    - Without the macro: the same reads give error=0, and address 1026 reads word 0.

Source files
------------

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - multi-cycle word data memory responder for the memory stage (optional MEM_ALIGN_CHECK_EN fault checking)
module data_memory_unit #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryReadEnabled,
  input  logic        memoryWriteEnabled,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic               fault_q, fault_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               mem_we;
  logic [31:0]        mem_q [DEPTH];

  logic               req;
  logic               req_fault;
  logic [IDX_W-1:0]   req_idx;

  assign req     = memoryReadEnabled | memoryWriteEnabled;
  // Word index wraps modulo DEPTH; the cast keeps only the low index bits.
  assign req_idx = IDX_W'((address - BASE_ADDR) >> 2);

`ifdef MEM_ALIGN_CHECK_EN
  assign req_fault = (address[1:0] != 2'b00) || (address < BASE_ADDR) ||
                     (address >= BASE_ADDR + 4 * DEPTH);
`else
  assign req_fault = 1'b0;
`endif

  assign readData = rdata_q;
  assign error    = err_q;

  // Next-state logic: accept in IDLE, count down in ACCESS, one-cycle DONE handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    ready   = 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          ready   = 1'b0;
          idx_d   = req_idx;
          wdata_d = writeData;
          is_wr_d = memoryWriteEnabled;
          fault_d = req_fault;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
          err_d   = fault_q;
          if (is_wr_q) begin
            mem_we = ~fault_q;
          end else begin
            rdata_d = fault_q ? 32'h0 : mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; not cleared by reset, but a reset cancels a store due this edge.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - scoreboard testbench for data_memory_unit
module tb_data_memory_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned LAT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memoryReadEnabled = 1'b0;
  logic        memoryWriteEnabled = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        ready;
  logic        error;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  data_memory_unit #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .memoryReadEnabled(memoryReadEnabled),
    .memoryWriteEnabled(memoryWriteEnabled),
    .address(address),
    .writeData(writeData),
    .readData(readData),
    .ready(ready),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic bit is_fault(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off & (DEPTH - 1));
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int drop_at, input bit hold,
                        input string name);
    exp_t e;
    bit   f;
    int   idx;
    int   n;
    f     = is_fault(addr);
    idx   = word_idx(addr);
    e.err = f;
    if (wr) begin
      e.data = last_rd;
      if (!f) model[idx] = data;
    end else begin
      e.data  = f ? 32'h0 : model[idx];
      last_rd = e.data;
    end
    sb.push_back(e);
    memoryReadEnabled  = rd;
    memoryWriteEnabled = wr;
    address            = addr;
    writeData          = data;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s request_ready got %b exp 0", name, ready);
    end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) break;
      if (n == drop_at) begin
        memoryReadEnabled  = 1'b0;
        memoryWriteEnabled = 1'b0;
      end
    end
    n_checks++;
    if (n != LAT + 1) begin
      n_fail++;
      $display("FAIL %s latency got %0d exp %0d", name, n, LAT + 1);
    end
    e = sb.pop_front();
    n_checks++;
    if (readData !== e.data) begin
      n_fail++;
      $display("FAIL %s readData got %h exp %h", name, readData, e.data);
    end
    n_checks++;
    if (error !== e.err) begin
      n_fail++;
      $display("FAIL %s error got %b exp %b", name, error, e.err);
    end
    if (!hold) begin
      memoryReadEnabled  = 1'b0;
      memoryWriteEnabled = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (readData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_readData got %h exp 0", readData);
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 1", ready);
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_error got %b exp 0", error);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 0, 1'b0, "store_1032");
    access(1'b1, 1'b0, 32'd1032, 32'h0, 0, 1'b0, "load_1032");
  endtask

  task automatic test_both_enables();
    access(1'b1, 1'b1, 32'd1024, 32'h11, 0, 1'b0, "both_1024");
    access(1'b1, 1'b0, 32'd1024, 32'h0, 0, 1'b0, "load_1024");
  endtask

  task automatic test_drop_enables();
    access(1'b0, 1'b1, 32'd1028, 32'h55, 2, 1'b0, "drop_store_1028");
    access(1'b1, 1'b0, 32'd1028, 32'h0, 0, 1'b0, "load_1028");
  endtask

  task automatic test_reset_mid_access();
    access(1'b0, 1'b1, 32'd1036, 32'h0, 0, 1'b0, "init_1036");
    memoryWriteEnabled = 1'b1;
    address            = 32'd1036;
    writeData          = 32'h77;
    @(negedge clk);
    @(negedge clk);
    rst                = 1'b0;
    memoryWriteEnabled = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_rd = 32'h0;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready got %b exp 1", ready);
    end
    n_checks++;
    if (readData !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_readData got %h exp 0", readData);
    end
    access(1'b1, 1'b0, 32'd1036, 32'h0, 0, 1'b0, "load_1036");
  endtask

  task automatic test_align();
    access(1'b1, 1'b0, 32'd1026, 32'h0, 0, 1'b0, "load_1026");
    access(1'b1, 1'b0, BASE + 4 * DEPTH, 32'h0, 0, 1'b0, "load_top");
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'd1040, 32'hA5A5_0001, 0, 1'b1, "b2b_store");
    access(1'b1, 1'b0, 32'd1040, 32'h0, 0, 1'b1, "b2b_load0");
    access(1'b1, 1'b0, 32'd1040, 32'h0, 0, 1'b0, "b2b_load1");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      d = $urandom;
      access(1'b0, 1'b1, a, d, 0, 1'b0, "rnd_store");
      access(1'b1, 1'b0, a, 32'h0, 0, 1'b0, "rnd_load");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, BASE + 4 * i, 32'h0, 0, 1'b0, "clear");
    end
    test_store_load();
    test_both_enables();
    test_drop_enables();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
